boid_frame_engine: RTL and testbench

Parametrised multi-boid update engine, and the next generation of the single-boid accelerator. It holds state for `N_BOIDS` boids in Q(W-FRAC).FRAC signed fixed point. On each `start` it steps every boid once: margin turning, alpha-max-beta-min speed clamp, then position integration. Updated positions and previous positions stream out over a valid/ready port to the VGA drawing logic, which erases and redraws.

---
 rtl/boid_frame_engine.sv | 203 ++++++++++++++++++++
 tb/tb_boid_frame_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_engine.sv
// boid_frame_engine
//   Steps N_BOIDS boids once per `start`. Each boid goes through margin turning,
//   an alpha-max-beta-min speed clamp and position integration. Each result is
//   streamed out over a valid/ready port so the drawing logic can erase the old
//   position and draw the new one.
//   All state is signed Q(W-FRAC).FRAC. Arithmetic wraps modulo 2^W.
// Ports
//   clk, reset (async, active low)
//   start            : frame request (sampled in IDLE only)
//   ld_en/ld_idx/ld_*: write one boid's state (IDLE only)
//   out_valid/out_ready, out_idx, x,y (new pos), px,py (old pos), vx,vy (new vel)
//   busy             : engine not idle
//   done             : one-cycle pulse at frame end
module boid_frame_engine #(
  parameter int W         = 32,
  parameter int FRAC      = 16,
  parameter int N_BOIDS   = 4,
  parameter int LEFT      = 100,
  parameter int RIGHT     = 540,
  parameter int TOP       = 100,
  parameter int BOTTOM    = 380,
  parameter int TURN      = 16384,
  parameter int MAX_SPEED = 6,
  parameter int MIN_SPEED = 3,
  parameter int SHRINK_SH = 3,
  parameter int X0        = 180,
  parameter int SPACING   = 40,
  parameter int Y0        = 240,
  parameter int V0        = 4,
  localparam int IW       = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_en,
  input  logic [IW-1:0] ld_idx,
  input  logic [W-1:0]  ld_x,
  input  logic [W-1:0]  ld_y,
  input  logic [W-1:0]  ld_vx,
  input  logic [W-1:0]  ld_vy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [W-1:0]  px,
  output logic [W-1:0]  py,
  output logic [W-1:0]  vx,
  output logic [W-1:0]  vy,
  output logic          busy,
  output logic          done
);

  localparam int W1 = W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EDGE  = 3'd2;
  localparam logic [2:0] S_SPEED = 3'd3;
  localparam logic [2:0] S_LIMIT = 3'd4;
  localparam logic [2:0] S_MOVE  = 3'd5;
  localparam logic [2:0] S_EMIT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Integer pixel value to raw Q value.
  function automatic logic [W-1:0] q(input int v);
    return W'(v) << FRAC;
  endfunction

  localparam logic signed [W-1:0] LEFT_Q   = signed'(q(LEFT));
  localparam logic signed [W-1:0] RIGHT_Q  = signed'(q(RIGHT));
  localparam logic signed [W-1:0] TOP_Q    = signed'(q(TOP));
  localparam logic signed [W-1:0] BOTTOM_Q = signed'(q(BOTTOM));
  localparam logic signed [W-1:0] TURN_Q   = W'(TURN);
  localparam logic [W:0]          MAX_Q    = W1'(MAX_SPEED) << FRAC;
  localparam logic [W:0]          MIN_Q    = W1'(MIN_SPEED) << FRAC;
  localparam logic [IW-1:0]       LAST     = IW'(N_BOIDS - 1);

  logic [2:0]    state;
  logic [IW-1:0] idx;

  logic [N_BOIDS-1:0][W-1:0] st_x, st_y, st_vx, st_vy;

  logic signed [W-1:0] wx, wy, wvx, wvy;
  logic [W:0]          spd;

  // Speed estimate on unsigned magnitudes. The extra bit keeps max+min/2
  // from wrapping when the velocities are near full scale.
  logic [W-1:0] ax, ay, mx, mn;
  logic [W:0]   spd_c;

  assign ax    = wvx[W-1] ? W'(-wvx) : W'(wvx);
  assign ay    = wvy[W-1] ? W'(-wvy) : W'(wvy);
  assign mx    = (ax > ay) ? ax : ay;
  assign mn    = (ax > ay) ? ay : ax;
  assign spd_c = {1'b0, mx} + {1'b0, mn >> 1};

  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_idx   = idx;

  // Boid store. It is written by the loader in IDLE and by the EMIT handshake.
  // Reset restores the initial formation, which discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BOIDS; i++) begin
        st_x[i]  <= q(X0 + i * SPACING);
        st_y[i]  <= q(Y0);
        st_vx[i] <= q((i % 2 == 0) ? V0 : -V0);
        st_vy[i] <= q(V0);
      end
    end else if (state == S_IDLE && ld_en && int'(ld_idx) < N_BOIDS) begin
      st_x[ld_idx]  <= ld_x;
      st_y[ld_idx]  <= ld_y;
      st_vx[ld_idx] <= ld_vx;
      st_vy[ld_idx] <= ld_vy;
    end else if (state == S_EMIT && out_ready) begin
      st_x[idx]  <= x;
      st_y[idx]  <= y;
      st_vx[idx] <= vx;
      st_vy[idx] <= vy;
    end
  end

  // Frame sequencer and the per-boid datapath. The store write above and the
  // start below share the IDLE edge. A load issued together with start is
  // therefore visible when LOAD reads the store one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      wx    <= '0;
      wy    <= '0;
      wvx   <= '0;
      wvy   <= '0;
      spd   <= '0;
      x     <= '0;
      y     <= '0;
      px    <= '0;
      py    <= '0;
      vx    <= '0;
      vy    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD;
          idx   <= '0;
        end
        S_LOAD: begin
          wx    <= st_x[idx];
          wy    <= st_y[idx];
          wvx   <= st_vx[idx];
          wvy   <= st_vy[idx];
          state <= S_EDGE;
        end
        S_EDGE: begin
          if (wx < LEFT_Q)        wvx <= wvx + TURN_Q;
          else if (wx > RIGHT_Q)  wvx <= wvx - TURN_Q;
          if (wy < TOP_Q)         wvy <= wvy + TURN_Q;
          else if (wy > BOTTOM_Q) wvy <= wvy - TURN_Q;
          state <= S_SPEED;
        end
        S_SPEED: begin
          spd   <= spd_c;
          state <= S_LIMIT;
        end
        S_LIMIT: begin
          if (spd > MAX_Q) begin
            wvx <= wvx - (wvx >>> SHRINK_SH);
            wvy <= wvy - (wvy >>> SHRINK_SH);
          end else if (spd < MIN_Q) begin
            wvx <= wvx + (wvx >>> SHRINK_SH);
            wvy <= wvy + (wvy >>> SHRINK_SH);
          end
          state <= S_MOVE;
        end
        S_MOVE: begin
          // The working position is still the pre-move position, so it
          // becomes px/py.
          x     <= wx + wvx;
          y     <= wy + wvy;
          px    <= wx;
          py    <= wy;
          vx    <= wvx;
          vy    <= wvy;
          state <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_frame_engine.sv
// Self-checking bench for boid_frame_engine. A behavioural boid model written
// with plain integer arithmetic predicts every emitted record and the frame timing.
module tb_boid_frame_engine;
  localparam int N      = 4;
  localparam int FRAC   = 16;
  localparam int LEFT   = 100 << FRAC;
  localparam int RIGHT  = 540 << FRAC;
  localparam int TOP    = 100 << FRAC;
  localparam int BOTTOM = 380 << FRAC;
  localparam int TURN   = 16384;

  logic        clk = 0, reset = 1, start = 0, ld_en = 0, out_ready = 1;
  logic [1:0]  ld_idx = 0;
  logic [31:0] ld_x = 0, ld_y = 0, ld_vx = 0, ld_vy = 0;
  logic        out_valid, busy, done;
  logic [1:0]  out_idx;
  logic [31:0] x, y, px, py, vx, vy;

  boid_frame_engine dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_x(ld_x), .ld_y(ld_y), .ld_vx(ld_vx), .ld_vy(ld_vy),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .x(x), .y(y), .px(px), .py(py), .vx(vx), .vy(vy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: current store and predicted frame results.
  int mx[N], my[N], mvx[N], mvy[N];
  int ex[N], ey[N], epx[N], epy[N], evx[N], evy[N];
  logic [31:0] obs_x[N], obs_y[N], obs_px[N], obs_py[N], obs_vx[N];

  function automatic void model_init();
    for (int i = 0; i < N; i++) begin
      mx[i]  = (180 + 40 * i) << FRAC;
      my[i]  = 240 << FRAC;
      mvx[i] = (i % 2 == 0) ? (4 << FRAC) : -(4 << FRAC);
      mvy[i] = 4 << FRAC;
    end
  endfunction

  function automatic void model_load(input int i, input int lx, input int ly,
                                     input int lvx, input int lvy);
    if (i < N) begin
      mx[i] = lx; my[i] = ly; mvx[i] = lvx; mvy[i] = lvy;
    end
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < N; i++) begin
      int bx = mx[i], by = my[i], bvx = mvx[i], bvy = mvy[i];
      longint ax, ay, hi, lo, s;
      if (bx < LEFT) bvx += TURN; else if (bx > RIGHT) bvx -= TURN;
      if (by < TOP) bvy += TURN; else if (by > BOTTOM) bvy -= TURN;
      ax = (bvx < 0) ? -longint'(bvx) : longint'(bvx);
      ay = (bvy < 0) ? -longint'(bvy) : longint'(bvy);
      hi = (ax > ay) ? ax : ay;
      lo = (ax > ay) ? ay : ax;
      s  = hi + lo / 2;
      if (s > (longint'(6) << FRAC)) begin
        bvx -= bvx >>> 3; bvy -= bvy >>> 3;
      end else if (s < (longint'(3) << FRAC)) begin
        bvx += bvx >>> 3; bvy += bvy >>> 3;
      end
      epx[i] = bx; epy[i] = by;
      ex[i] = bx + bvx; ey[i] = by + bvy;
      evx[i] = bvx; evy[i] = bvy;
    end
  endfunction

  task automatic do_reset();
    reset = 0; start = 0; ld_en = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    model_init();
  endtask

  task automatic load(input int i, input int lx, input int ly, input int lvx, input int lvy);
    @(negedge clk);
    ld_en = 1; ld_idx = 2'(i); ld_x = lx; ld_y = ly; ld_vx = lvx; ld_vy = lvy;
    model_load(i, lx, ly, lvx, lvy);
    @(negedge clk);
    ld_en = 0;
  endtask

  // One frame. t counts cycles after the start edge, so t == 1 is LOAD of boid 0.
  task automatic run_frame(input int stall, input bit disturb, input bit co_load);
    int t, bi, sacc;
    bit fin;
    logic [31:0] sx, svx;
    @(negedge clk);
    start = 1;
    if (co_load) begin
      ld_en = 1;
      model_load(int'(ld_idx), ld_x, ld_y, ld_vx, ld_vy);
    end
    @(negedge clk);
    start = 0; ld_en = 0;
    model_frame();
    t = 1; bi = 0; sacc = 0; fin = 0;
    chk("busy_k1", busy, 1);
    while (!fin && t < 400) begin
      if (disturb) begin
        start = (t % 4 == 2);
        ld_en = (t % 5 == 3);
        ld_idx = 2'($urandom); ld_x = $urandom; ld_y = $urandom;
        ld_vx = $urandom; ld_vy = $urandom;
      end
      if (out_valid) begin
        if (bi < N) begin
          chk("emit_t", t, 6 * (bi + 1) + sacc);
          chk("idx", out_idx, bi);
          chk("x", x, ex[bi]);   chk("y", y, ey[bi]);
          chk("px", px, epx[bi]); chk("py", py, epy[bi]);
          chk("vx", vx, evx[bi]); chk("vy", vy, evy[bi]);
          obs_x[bi] = x; obs_y[bi] = y; obs_px[bi] = px; obs_py[bi] = py; obs_vx[bi] = vx;
          if (bi == 0 && stall > 0) begin
            out_ready = 0; sx = x; svx = vx;
            for (int s = 0; s < stall; s++) begin
              @(negedge clk); t++;
              chk("stall_vld", out_valid, 1);
              chk("stall_x", x, sx);
              chk("stall_vx", vx, svx);
            end
            out_ready = 1; sacc = stall;
          end
        end else begin
          chk("extra_emit", bi, N - 1);
        end
        bi++;
      end
      if (done) begin
        chk("done_t", t, 6 * N + 1 + sacc);
        chk("done_busy", busy, 1);
        chk("done_cnt", bi, N);
        if (disturb) start = 1;  // DONE is not IDLE: must be ignored
        fin = 1;
      end
      @(negedge clk); t++;
    end
    start = 0; ld_en = 0;
    chk("done_seen", fin, 1);
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
    for (int i = 0; i < N; i++) begin
      mx[i] = ex[i]; my[i] = ey[i]; mvx[i] = evx[i]; mvy[i] = evy[i];
    end
  endtask

  task automatic chk_first_frame(input string tag);
    chk({tag, "_x0"}, obs_x[0], 32'h00B80000);
    chk({tag, "_y0"}, obs_y[0], 32'h00F40000);
    chk({tag, "_px0"}, obs_px[0], 32'h00B40000);
    chk({tag, "_py0"}, obs_py[0], 32'h00F00000);
    chk({tag, "_x1"}, obs_x[1], 32'h00D80000);
    chk({tag, "_vx1"}, obs_vx[1], 32'hFFFC0000);
  endtask

  initial begin
    #2 reset = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_idx", out_idx, 0); chk("rst_x", x, 0); chk("rst_y", y, 0);
    chk("rst_px", px, 0); chk("rst_py", py, 0); chk("rst_vx", vx, 0); chk("rst_vy", vy, 0);
    @(negedge clk);
    reset = 1;
    model_init();

    // Default formation.
    run_frame(0, 0, 0);
    chk_first_frame("f1");

    // Left-margin turn plus minimum-speed boost, with the load issued together with start.
    ld_idx = 0; ld_x = 90 << FRAC; ld_y = 240 << FRAC; ld_vx = 2 << FRAC; ld_vy = 0;
    run_frame(0, 0, 1);
    chk("turn_vx", obs_vx[0], 32'h00028800);
    chk("turn_x", obs_x[0], 32'h005C8800);
    chk("turn_y", obs_y[0], 32'h00F00000);

    // Over-speed clamp in both directions.
    load(0, 300 << FRAC, 240 << FRAC, 8 << FRAC, 0);
    run_frame(0, 0, 0);
    chk("fast_vx", obs_vx[0], 32'h00070000);
    chk("fast_x", obs_x[0], 32'h01330000);
    load(0, 300 << FRAC, 240 << FRAC, -(8 << FRAC), 0);
    run_frame(0, 0, 0);
    chk("fastn_vx", obs_vx[0], 32'hFFF90000);
    chk("fastn_x", obs_x[0], 32'h01250000);

    // Boundaries: exactly on the margins, speed exactly MAX, zero velocity.
    load(1, LEFT, BOTTOM, 4 << FRAC, 0);
    load(2, 300 << FRAC, 200 << FRAC, 6 << FRAC, 0);
    load(3, 300 << FRAC, 240 << FRAC, 0, 0);
    run_frame(0, 0, 0);
    chk("zero_vx", obs_vx[3], 0);

    // Backpressure at the first EMIT.
    do_reset();
    run_frame(10, 0, 0);
    chk_first_frame("stall");

    // start/ld_en activity while busy.
    run_frame(0, 1, 0);

    // Reset during SPEED of boid 2 (t == 15).
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1;
    model_init();
    run_frame(0, 0, 0);
    chk_first_frame("postrst");

    // Randomized states, including full-range values that exercise wrap.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          if (r == 4)
            load(i, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
          else
            load(i, int'($urandom_range(0, 640 << FRAC)), int'($urandom_range(0, 480 << FRAC)),
                 int'($urandom_range(0, 20 << FRAC)) - (10 << FRAC),
                 int'($urandom_range(0, 20 << FRAC)) - (10 << FRAC));
        end
      end
      run_frame((r == 2) ? int'($urandom_range(1, 5)) : 0, r[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
